// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and flag bit positions shared by the ALU execute pipe.
package alu_pkg;
   localparam logic [2:0] SEL_ADD  = 3'd0;
   localparam logic [2:0] SEL_AND  = 3'd1;
   localparam logic [2:0] SEL_NAND = 3'd2;
   localparam logic [2:0] SEL_NOR  = 3'd3;
   localparam logic [2:0] SEL_OR   = 3'd4;
   localparam logic [2:0] SEL_XOR  = 3'd5;
   localparam logic [2:0] SEL_SLT  = 3'd6;
   localparam logic [2:0] SEL_ILL  = 3'd7;
   localparam int FLG_CARRY = 0;
   localparam int FLG_OVF   = 1;
   localparam int FLG_ZERO  = 2;
   localparam int FLG_ILL   = 3;
   localparam int NFLAGS    = 4;
endpackage

// File: rtl/alu_exec_core.sv
// alu_exec_core: combinational ALU producing result and carry/overflow/zero/illegal flags.
module alu_exec_core
   import alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   sel,
   input  logic         invert,
   output logic [W-1:0] result,
   output logic         carryout,
   output logic         overflow,
   output logic         zero,
   output logic         illegal
);
   logic [W-1:0] w_bb;
   logic [W-1:0] w_sum;
   logic [W-1:0] w_raw;
   logic         w_c;
   logic         w_ovf;
   logic         w_arith;

   assign w_bb = invert ? ~b : b;
   assign {w_c, w_sum} = {1'b0, a} + {1'b0, w_bb} + {{W{1'b0}}, invert};
   assign w_ovf = (a[W-1] == w_bb[W-1]) && (w_sum[W-1] != a[W-1]);
   assign illegal = (sel == SEL_ILL) || (sel == SEL_SLT && !invert);
   assign w_arith = !illegal && (sel == SEL_ADD || sel == SEL_SLT);

   always_comb begin
      w_raw = '0;
      case (sel)
         SEL_ADD:  w_raw = w_sum;
         SEL_AND:  w_raw = a & b;
         SEL_NAND: w_raw = ~(a & b);
         SEL_NOR:  w_raw = ~(a | b);
         SEL_OR:   w_raw = a | b;
         SEL_XOR:  w_raw = a ^ b;
         SEL_SLT:  w_raw = {{(W-1){1'b0}}, w_sum[W-1] ^ w_ovf};
         default:  w_raw = '0;
      endcase
   end

   assign result   = illegal ? '0 : w_raw;
   assign carryout = w_arith && w_c;
   assign overflow = w_arith && w_ovf;
   assign zero     = (result == '0);
endmodule

// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: two-stage valid/ready execute pipe; stage 1 holds operands, stage 2 holds result and flags.
module alu_exec_pipe
   import alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   sel,
   input  logic         invert,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         carryout,
   output logic         overflow,
   output logic         zero,
   output logic         illegal
);
   logic              r_s1_valid;
   logic [W-1:0]      r_a;
   logic [W-1:0]      r_b;
   logic [2:0]        r_sel;
   logic              r_inv;
   logic              r_s2_valid;
   logic [W-1:0]      r_result;
   logic [NFLAGS-1:0] r_flags;
   logic              w_s2_load;
   logic              w_s1_adv;
   logic              w_accept;
   logic [W-1:0]      w_result;
   logic              w_carry;
   logic              w_ovf;
   logic              w_zero;
   logic              w_ill;

   assign w_s2_load = !r_s2_valid || out_ready;
   assign w_s1_adv  = r_s1_valid && w_s2_load;
   // in_ready follows out_ready combinationally: there is no skid buffer behind stage 1
   assign in_ready  = !flush && (!r_s1_valid || w_s1_adv);
   assign w_accept  = in_valid && in_ready;

   alu_exec_core #(.W(W)) u_core (
      .a        (r_a),
      .b        (r_b),
      .sel      (r_sel),
      .invert   (r_inv),
      .result   (w_result),
      .carryout (w_carry),
      .overflow (w_ovf),
      .zero     (w_zero),
      .illegal  (w_ill)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_sel      <= '0;
         r_inv      <= 1'b0;
      end else begin
         if (flush) r_s1_valid <= 1'b0;
         else if (w_accept) r_s1_valid <= 1'b1;
         else if (w_s1_adv) r_s1_valid <= 1'b0;
         if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_sel <= sel;
            r_inv <= invert;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_flags    <= '0;
      end else begin
         if (flush) r_s2_valid <= 1'b0;
         else if (w_s2_load) r_s2_valid <= r_s1_valid;
         if (w_s1_adv) begin
            r_result           <= w_result;
            r_flags[FLG_CARRY] <= w_carry;
            r_flags[FLG_OVF]   <= w_ovf;
            r_flags[FLG_ZERO]  <= w_zero;
            r_flags[FLG_ILL]   <= w_ill;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign result    = r_result;
   assign carryout  = r_flags[FLG_CARRY];
   assign overflow  = r_flags[FLG_OVF];
   assign zero      = r_flags[FLG_ZERO];
   assign illegal   = r_flags[FLG_ILL];
endmodule

// File: tb/tb_alu_exec_pipe.sv
// tb_alu_exec_pipe: directed self-checking bench for the ALU execute pipe.
module tb_alu_exec_pipe;
   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  sel;
   logic        invert;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        carryout;
   logic        overflow;
   logic        zero;
   logic        illegal;
   int          errors;
   int          checks;

   alu_exec_pipe #(.W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .invert    (invert),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carryout  (carryout),
      .overflow  (overflow),
      .zero      (zero),
      .illegal   (illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // flags are packed {illegal, zero, overflow, carryout}
   task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [2:0] ts, input logic ti,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
      @(negedge clk);
      a = ta; b = tb_v; sel = ts; invert = ti; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 6) begin
         @(negedge clk);
         lat++;
      end
      r = result;
      f = {illegal, zero, overflow, carryout};
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, result, illegal, zero, overflow, carryout} !== 37'd0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b result=%h flags=%b%b%b%b, want all 0",
                  out_valid, result, illegal, zero, overflow, carryout);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_arith;
      logic [31:0] r;
      logic [3:0]  f;
      int          lat;
      do_op(32'hFFFFFFFF, 32'h1, 3'd0, 1'b0, r, f, lat);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d want 2", lat); end
      checks++;
      if ({r, f} !== {32'h0, 4'b0101}) begin errors++; $display("FAIL add_wrap: got %h/%b want 00000000/0101", r, f); end
      do_op(32'h80000000, 32'h1, 3'd0, 1'b1, r, f, lat);
      checks++;
      if ({r, f} !== {32'h7FFFFFFF, 4'b0011}) begin errors++; $display("FAIL sub_ovf: got %h/%b want 7fffffff/0011", r, f); end
      do_op(32'h7FFFFFFF, 32'h1, 3'd0, 1'b0, r, f, lat);
      checks++;
      if ({r, f} !== {32'h80000000, 4'b0010}) begin errors++; $display("FAIL add_ovf: got %h/%b want 80000000/0010", r, f); end
   endtask

   task automatic test_slt;
      logic [31:0] r;
      logic [3:0]  f;
      int          lat;
      do_op(32'hFFFFFFFF, 32'h1, 3'd6, 1'b1, r, f, lat);
      checks++;
      if ({r, f} !== {32'h1, 4'b0001}) begin errors++; $display("FAIL slt_neg: got %h/%b want 00000001/0001", r, f); end
      do_op(32'h1, 32'hFFFFFFFF, 3'd6, 1'b1, r, f, lat);
      checks++;
      if ({r, f} !== {32'h0, 4'b0100}) begin errors++; $display("FAIL slt_pos: got %h/%b want 00000000/0100", r, f); end
      do_op(32'h80000000, 32'h1, 3'd6, 1'b1, r, f, lat);
      checks++;
      if ({r, f} !== {32'h1, 4'b0011}) begin errors++; $display("FAIL slt_ovf: got %h/%b want 00000001/0011", r, f); end
   endtask

   task automatic test_logic;
      logic [31:0] r;
      logic [3:0]  f;
      int          lat;
      do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'd2, 1'b0, r, f, lat);
      checks++;
      if ({r, f} !== {32'h0FFF0FFF, 4'b0000}) begin errors++; $display("FAIL nand: got %h/%b want 0fff0fff/0000", r, f); end
      do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'd1, 1'b1, r, f, lat);
      checks++;
      if ({r, f} !== {32'hF000F000, 4'b0000}) begin errors++; $display("FAIL and: got %h/%b want f000f000/0000", r, f); end
      do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'd3, 1'b0, r, f, lat);
      checks++;
      if ({r, f} !== {32'h000F000F, 4'b0000}) begin errors++; $display("FAIL nor: got %h/%b want 000f000f/0000", r, f); end
      do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'd4, 1'b0, r, f, lat);
      checks++;
      if ({r, f} !== {32'hFFF0FFF0, 4'b0000}) begin errors++; $display("FAIL or: got %h/%b want fff0fff0/0000", r, f); end
      do_op(32'hF0F0F0F0, 32'hF0F0F0F0, 3'd5, 1'b0, r, f, lat);
      checks++;
      if ({r, f} !== {32'h0, 4'b0100}) begin errors++; $display("FAIL xor_zero: got %h/%b want 00000000/0100", r, f); end
      do_op(32'h12345678, 32'h1, 3'd7, 1'b1, r, f, lat);
      checks++;
      if ({r, f} !== {32'h0, 4'b1100}) begin errors++; $display("FAIL sel7: got %h/%b want 00000000/1100", r, f); end
      do_op(32'h1, 32'h2, 3'd6, 1'b0, r, f, lat);
      checks++;
      if ({r[31:0], f[3]} !== {32'h0, 1'b1}) begin errors++; $display("FAIL slt_noinv: got %h ill=%b want 00000000 ill=1", r, f[3]); end
   endtask

   task automatic test_back_to_back;
      int          tx;
      int          rx;
      logic [31:0] held;
      logic        held_v;
      tx = 0; rx = 0; held_v = 1'b0; held = '0;
      for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 4 && cyc <= 6);
         in_valid = (tx < 8);
         a = 32'(tx + 1); b = 32'h10; sel = 3'd0; invert = 1'b0;
         #1;
         if (cyc >= 4 && cyc <= 6) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b want 0", cyc, in_ready); end
         end
         if (held_v) begin
            checks++;
            if ({out_valid, result} !== {1'b1, held}) begin
               errors++;
               $display("FAIL stall_hold: cycle %0d got valid=%b result=%h want valid=1 result=%h", cyc, out_valid, result, held);
            end
         end
         held_v = out_valid && !out_ready;
         held = result;
         if (out_valid && out_ready) begin
            checks++;
            if (result !== 32'(rx + 17)) begin errors++; $display("FAIL b2b_order: item %0d got %h want %h", rx, result, 32'(rx + 17)); end
            rx++;
         end
         if (in_valid && in_ready) tx++;
      end
      checks++;
      if (rx !== 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", rx); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_reset_flush;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; a = 32'd5; b = 32'd6; sel = 3'd0; invert = 1'b0;
      @(negedge clk);
      a = 32'd7;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL inflight_valid: got %b want 1", out_valid); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset: out_valid got %b want 0", out_valid); end
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_pulse: cycle %0d out_valid got %b want 0", k, out_valid); end
      end
      out_ready = 1'b0; in_valid = 1'b1; a = 32'd9;
      @(negedge clk);
      flush = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_empty: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept: out_valid got %b want 0", out_valid); end
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sel = '0; invert = 1'b0;
      test_reset;
      test_arith;
      test_slt;
      test_logic;
      test_back_to_back;
      test_reset_flush;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
